// File: rtl/large_matrix_mult.sv
// Streaming N x N unsigned matrix multiplier: loads A then B beat-by-beat, computes
// one C element per cycle, then streams C out on demand. Results wrap modulo 2^WIDTH.
module large_matrix_mult #(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4,
    parameter int MATRIX_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [NUM_ELEMENTS*WIDTH-1:0]   Res,
    input  logic [NUM_ELEMENTS*WIDTH-1:0]   rdata,
    input  logic                            read_en,
    input  logic                            write_en,
    output logic                            write_ready
);

    localparam int N      = MATRIX_WIDTH;
    localparam int BPR    = MATRIX_WIDTH / NUM_ELEMENTS;
    localparam int BEAT_W = NUM_ELEMENTS * WIDTH;
    localparam int ROW_W  = N * WIDTH;
    localparam int RW     = (N > 1) ? $clog2(N) : 1;
    localparam int SW     = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
    localparam logic [SW-1:0] SEG_LAST = SW'(BPR - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [SW-1:0]       seg_q, seg_d;
    logic [RW-1:0]       i_q, i_d;
    logic [RW-1:0]       j_q, j_d;
    logic [BEAT_W-1:0]   res_q, res_d;
    logic                write_ready_q, write_ready_d;

    // Each matrix row is one packed vector so beats and elements are plain part-selects.
    logic [ROW_W-1:0]    a_q [N];
    logic [ROW_W-1:0]    b_q [N];
    logic [ROW_W-1:0]    c_q [N];

    logic [31:0]         beat_off;
    logic [31:0]         col_off;
    logic [ROW_W-1:0]    a_row;
    logic [ROW_W-1:0]    b_col;
    logic [WIDTH-1:0]    dot;

    logic                beat_last;
    logic                elem_last;
    logic [RW-1:0]       row_nx;
    logic [SW-1:0]       seg_nx;
    logic [RW-1:0]       i_nx;
    logic [RW-1:0]       j_nx;

    assign beat_off = 32'(seg_q) * BEAT_W;
    assign col_off  = 32'(j_q) * WIDTH;
    assign a_row    = a_q[i_q];

    for (genvar gi = 0; gi < N; gi++) begin : g_bcol
        assign b_col[gi*WIDTH +: WIDTH] = b_q[gi][col_off +: WIDTH];
    end

    // Products are truncated to WIDTH on purpose: only the low bits of C are kept.
    always_comb begin
        dot = '0;
        for (int k = 0; k < N; k++) begin
            dot = dot + a_row[k*WIDTH +: WIDTH] * b_col[k*WIDTH +: WIDTH];
        end
    end

    assign beat_last = (row_q == ROW_LAST) && (seg_q == SEG_LAST);
    assign seg_nx    = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
    assign row_nx    = (seg_q != SEG_LAST) ? row_q :
                       (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

    assign elem_last = (i_q == ROW_LAST) && (j_q == ROW_LAST);
    assign j_nx      = (j_q == ROW_LAST) ? '0 : j_q + 1'b1;
    assign i_nx      = (j_q != ROW_LAST) ? i_q :
                       (i_q == ROW_LAST) ? '0 : i_q + 1'b1;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        seg_d   = seg_q;
        i_d     = i_q;
        j_d     = j_q;
        res_d   = res_q;
        unique case (state_q)
            LOAD_A: begin
                if (read_en) begin
                    row_d = row_nx;
                    seg_d = seg_nx;
                    if (beat_last) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (read_en) begin
                    row_d = row_nx;
                    seg_d = seg_nx;
                    if (beat_last) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                i_d = i_nx;
                j_d = j_nx;
                if (elem_last) state_d = WRITE;
            end
            WRITE: begin
                if (write_en) begin
                    res_d = c_q[row_q][beat_off +: BEAT_W];
                    row_d = row_nx;
                    seg_d = seg_nx;
                    if (beat_last) state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
        write_ready_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LOAD_A;
            row_q         <= '0;
            seg_q         <= '0;
            i_q           <= '0;
            j_q           <= '0;
            res_q         <= '0;
            write_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            seg_q         <= seg_d;
            i_q           <= i_d;
            j_q           <= j_d;
            res_q         <= res_d;
            write_ready_q <= write_ready_d;
        end
    end

    // Storage is not reset: every run overwrites all of A, B and C before they are read.
    always_ff @(posedge clk) begin
        if (state_q == LOAD_A && read_en) begin
            a_q[row_q][beat_off +: BEAT_W] <= rdata;
        end
        if (state_q == LOAD_B && read_en) begin
            b_q[row_q][beat_off +: BEAT_W] <= rdata;
        end
        if (state_q == COMPUTE) begin
            c_q[i_q][col_off +: WIDTH] <= dot;
        end
    end

    assign Res         = res_q;
    assign write_ready = write_ready_q;

endmodule

// File: tb/tb_large_matrix_mult.sv
// Directed bench for large_matrix_mult at the default 4x4, 8-bit, one-beat-per-row size.
module tb_large_matrix_mult;

    logic        clk;
    logic        reset;
    logic [31:0] rdata;
    logic        read_en;
    logic        write_en;
    logic [31:0] Res;
    logic        write_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] res_hold;

    logic [31:0] ident_rows [4] = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    logic [31:0] b_rows     [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    logic [31:0] ff_rows    [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] four_rows  [4] = '{32'h04040404, 32'h04040404, 32'h04040404, 32'h04040404};

    large_matrix_mult #(
        .WIDTH       (8),
        .NUM_ELEMENTS(4),
        .MATRIX_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Res        (Res),
        .rdata      (rdata),
        .read_en    (read_en),
        .write_en   (write_en),
        .write_ready(write_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // write_en stays high while loading to show it is ignored outside WRITE.
    task automatic load_matrix(input logic [31:0] rows [4], input bit toggle);
        write_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (toggle) begin
                read_en = 1'b0;
                rdata   = 32'hDEADBEEF;
                tick();
            end
            read_en = 1'b1;
            rdata   = rows[r];
            tick();
        end
        read_en = 1'b0;
        check_val("load_res_hold", Res, res_hold);
    endtask

    task automatic wait_ready(input string tag);
        int cnt;
        cnt      = 0;
        read_en  = 1'b1;
        rdata    = 32'hA5A5A5A5;
        write_en = 1'b1;
        while (write_ready !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        check_val({tag, "_compute_cycles"}, 32'(cnt), 32'd16);
    endtask

    task automatic read_result(input string tag, input logic [31:0] exp [4], input bit toggle);
        read_en = 1'b1;
        rdata   = 32'h5A5A5A5A;
        for (int r = 0; r < 4; r++) begin
            if (toggle) begin
                write_en = 1'b0;
                tick();
                check_val($sformatf("%s_hold%0d", tag, r), Res, res_hold);
                check_val($sformatf("%s_rdy_hold%0d", tag, r), 32'(write_ready), 32'd1);
            end
            write_en = 1'b1;
            tick();
            check_val($sformatf("%s_row%0d", tag, r), Res, exp[r]);
            check_val($sformatf("%s_rdy%0d", tag, r), 32'(write_ready), (r < 3) ? 32'd1 : 32'd0);
            res_hold = exp[r];
            $display("[TB] %s row %0d Res=0x%08h", tag, r, Res);
        end
        read_en  = 1'b0;
        write_en = 1'b1;
        tick();
        check_val({tag, "_final_hold"}, Res, res_hold);
        write_en = 1'b0;
    endtask

    initial begin
        int m;
        logic [31:0] exp_res;
        reset    = 1'b0;
        read_en  = 1'b1;
        write_en = 1'b1;
        rdata    = 32'h01010101;
        res_hold = 32'h0;

        repeat (5) begin
            tick();
            check_val("reset_res", Res, 32'h0);
            check_val("reset_rdy", 32'(write_ready), 32'd0);
        end

        reset = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            tick();
            m       = e % 28;
            exp_res = (e < 25) ? 32'h0 : 32'h04040404;
            check_val($sformatf("stream_rdy_e%0d", e), 32'(write_ready), (m >= 24) ? 32'd1 : 32'd0);
            check_val($sformatf("stream_res_e%0d", e), Res, exp_res);
            if (m >= 25 || m == 0) $display("[TB] stream edge %0d Res=0x%08h", e, Res);
        end
        res_hold = 32'h04040404;

        read_en  = 1'b0;
        write_en = 1'b0;
        tick();

        load_matrix(ident_rows, 1'b0);
        load_matrix(b_rows, 1'b0);
        wait_ready("ident");
        read_result("ident", b_rows, 1'b0);

        load_matrix(ff_rows, 1'b0);
        load_matrix(ff_rows, 1'b0);
        wait_ready("allff");
        read_result("allff", four_rows, 1'b0);

        load_matrix(ident_rows, 1'b1);
        load_matrix(b_rows, 1'b1);
        wait_ready("toggle");
        read_result("toggle", b_rows, 1'b1);

        load_matrix(ff_rows, 1'b0);
        load_matrix(ff_rows, 1'b0);
        read_en = 1'b1;
        rdata   = 32'h77777777;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check_val("abort_res", Res, 32'h0);
        check_val("abort_rdy", 32'(write_ready), 32'd0);
        tick();
        reset    = 1'b1;
        res_hold = 32'h0;
        load_matrix(ident_rows, 1'b0);
        load_matrix(b_rows, 1'b0);
        wait_ready("abort");
        read_result("abort", b_rows, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
